data_mem_ctrl: RTL

- Parametrised, byte-addressed, little-endian data memory with a valid/ready request port and a single-cycle response pulse.
- Supports RV32 loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3.
- Adds over the previous data memory: programmable wait states, automatic two-beat handling of misaligned accesses, range/illegal-op error reporting, and synchronous registered reads.
- Sits between the LSU/memory stage and backing storage; replaces the combinational memory so the pipeline can stall on req_ready.

---
 rtl/data_mem_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian RV32 data memory with valid/ready request,
// programmable wait states, two-beat misaligned access and error response.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned WAIT_STATES = 0,
  parameter              INIT_FILE   = "",
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int unsigned IW    = ADDR_WIDTH - 2;
  localparam logic [3:0]  WS_M1 =
    4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACC0, S_ACC1, S_RESP
  } state_t;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("data_mem_ctrl: DATA_WIDTH must be 32");
  end

  logic [31:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_nxt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [3:0]        r_cnt;
  logic [31:0]       r_buf;

  logic              w_hs;
  logic              w_legal;
  logic              w_req_err;
  logic [2:0]        w_req_size;
  logic [2:0]        w_size;
  logic [32:0]       w_end;
  logic              w_split;
  logic              w_acc;
  logic [IW-1:0]     w_idx;
  logic [1:0]        w_dsel [4];
  logic [3:0]        w_lane_en;
  logic [7:0]        w_wbyte [4];

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    unique case (f3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  always_comb begin
    w_req_size = size_of(req_funct3);
    w_legal    = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                        : (req_funct3 inside {3'b000, 3'b001, 3'b010,
                                              3'b100, 3'b101});
    // One sum catches both high address bits and running off the top.
    w_end      = {1'b0, req_addr} + {30'd0, w_req_size} - 33'd1;
    w_req_err  = !w_legal || (|w_end[32:ADDR_WIDTH]);
    w_hs       = req_valid && (r_state == S_IDLE);
    w_size     = size_of(r_f3);
    w_split    = ({1'b0, r_addr[1:0]} + w_size) > 3'd4;
    w_acc      = (r_state == S_ACC0) || (r_state == S_ACC1);
  end

  always_comb begin
    w_idx = (r_state == S_ACC1) ? r_addr[ADDR_WIDTH-1:2] + IW'(1)
                                : r_addr[ADDR_WIDTH-1:2];
    for (int l = 0; l < 4; l++) begin
      // Lane l always carries data byte (l - offset) mod 4 in either beat.
      w_dsel[l]    = 2'(l) - r_addr[1:0];
      w_lane_en[l] = ((r_state == S_ACC0) ? (2'(l) >= r_addr[1:0])
                                          : (2'(l) <  r_addr[1:0]))
                     && ({1'b0, w_dsel[l]} < w_size);
      w_wbyte[l]   = r_wdata[8*w_dsel[l] +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_hs) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr[ADDR_WIDTH-1:0];
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
        r_cnt   <= WS_M1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (req_valid) begin
          if (w_req_err)            w_nxt = S_RESP;
          else if (WAIT_STATES > 0) w_nxt = S_WAIT;
          else                      w_nxt = S_ACC0;
        end
      S_WAIT:  if (r_cnt == 4'd0) w_nxt = S_ACC0;
      S_ACC0:  w_nxt = w_split ? S_ACC1 : S_RESP;
      S_ACC1:  w_nxt = S_RESP;
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int l = 0; l < 4; l++) begin
        if (w_lane_en[l]) begin
          if (r_we) r_mem[w_idx][8*l +: 8] <= w_wbyte[l];
          else      r_buf[8*w_dsel[l] +: 8] <= r_mem[w_idx][8*l +: 8];
        end
      end
    end
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    rsp_err   = (r_state == S_RESP) && r_err;
    rsp_rdata = '0;
    if ((r_state == S_RESP) && !r_we && !r_err) begin
      case (r_f3)
        3'b000:  rsp_rdata = {{24{r_buf[7]}}, r_buf[7:0]};
        3'b001:  rsp_rdata = {{16{r_buf[15]}}, r_buf[15:0]};
        3'b100:  rsp_rdata = {24'd0, r_buf[7:0]};
        3'b101:  rsp_rdata = {16'd0, r_buf[15:0]};
        default: rsp_rdata = r_buf;
      endcase
    end
  end

endmodule
